// File: rtl/ws_psum_collector_pkg.sv
// Shared sizing helpers for the weight-stationary partial-sum collector.
// Everything that depends on a module parameter is derived through these functions.
package ws_psum_collector_pkg;

  localparam int ROW_COUNT_WIDTH = 16;

  // A partial sum is four operand widths wide to absorb accumulation growth.
  function automatic int psum_width(input int word_width);
    return word_width * 4;
  endfunction

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  // One extra bit so a full FIFO (count == depth) is distinct from empty.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/psum_column_fifo.sv
// Per-column circular buffer that de-skews one array column's partial sums.
// A push against a full buffer is accepted only when a pop frees a slot in the same cycle.
module psum_column_fifo
  import ws_psum_collector_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  empty,
  output logic                  full,
  output logic                  drop
);

  localparam int PTR_WIDTH = ptr_width(DEPTH);
  localparam int CNT_WIDTH = cnt_width(DEPTH);
  localparam logic [CNT_WIDTH-1:0] FULL_COUNT = CNT_WIDTH'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [PTR_WIDTH-1:0]  rd_ptr;
  logic [CNT_WIDTH-1:0]  count;
  logic                  pop_ok;
  logic                  push_ok;

  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && full && !pop_ok;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop_ok) begin
        count <= count + 1'b1;
      end else if (pop_ok && !push_ok) begin
        count <= count - 1'b1;
      end
    end
  end

  // Storage carries no reset; validity is tracked entirely by count.
  always_ff @(posedge clk) begin
    if (push_ok && !clear) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/ws_psum_collector.sv
// Collects skewed bottom-row partial sums from the weight-stationary array and
// re-aligns them into complete output rows for the writeback stream.
module ws_psum_collector
  import ws_psum_collector_pkg::*;
#(
  parameter int WORD_WIDTH = 8,
  parameter int COLS       = 4,
  parameter int DEPTH      = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              clear,
  input  logic [COLS-1:0]                   col_valid,
  input  logic [COLS*WORD_WIDTH*4-1:0]      col_psum,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [COLS*WORD_WIDTH*4-1:0]      out_row,
  output logic                              overflow,
  output logic [ROW_COUNT_WIDTH-1:0]        row_count
);

  localparam int PSUM_WIDTH = psum_width(WORD_WIDTH);

  logic [COLS-1:0]            col_empty;
  logic [COLS-1:0]            col_full;
  logic [COLS-1:0]            col_drop;
  logic [COLS*PSUM_WIDTH-1:0] heads;
  logic                       pop;

  for (genvar j = 0; j < COLS; j++) begin : gen_col
    psum_column_fifo #(
      .DATA_WIDTH (PSUM_WIDTH),
      .DEPTH      (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear),
      .push      (col_valid[j]),
      .push_data (col_psum[j*PSUM_WIDTH +: PSUM_WIDTH]),
      .pop       (pop),
      .head      (heads[j*PSUM_WIDTH +: PSUM_WIDTH]),
      .empty     (col_empty[j]),
      .full      (col_full[j]),
      .drop      (col_drop[j])
    );

    // A dropped push can only ever come from a column that was already full.
    assert property (@(posedge clk) disable iff (reset) col_drop[j] |-> col_full[j]);
  end

  // Output stream: a row transfers on any edge where out_valid && out_ready.
  // out_valid comes only from registered FIFO counts, out_row is held while
  // out_valid && !out_ready, and out_ready never feeds back into any output.
  assign out_valid = ~|col_empty;
  assign pop       = out_valid && out_ready;
  assign out_row   = out_valid ? heads : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      row_count <= '0;
    end else if (clear) begin
      overflow  <= 1'b0;
      row_count <= '0;
    end else begin
      if (|col_drop) overflow <= 1'b1;
      if (pop)       row_count <= row_count + 1'b1;
    end
  end

endmodule

// File: doc/ws_psum_collector.md
Name: ws_psum_collector

Overview:
- Receive side of the weight-stationary array's partial-sum path: sits under the bottom PE row and captures each column's `d_out` partial sum when the array flags it valid.
- Column outputs arrive skewed, with column j typically one cycle after column j-1. The block de-skews them through one FIFO per column.
- It presents complete output rows (one psum per column) on a valid/ready stream to the writeback logic.

Parameters:
- WORD_WIDTH, 8, operand width; partial-sum width is WORD_WIDTH*4.
- COLS, 4, number of array columns collected.
- DEPTH, 8, entries per column FIFO; power of two, >= 2.

Ports:
- clk  input  1  global clock.
- reset  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous flush of all FIFOs, overflow and row_count.
- col_valid  input  COLS  bit j set: col_psum slice j holds a valid partial sum this cycle.
- col_psum  input  COLS*WORD_WIDTH*4  bottom-row psums; column 0 in LSBs.
- out_valid  output  1  a complete row is available.
- out_ready  input  1  consumer accepts the row this cycle.
- out_row  output  COLS*WORD_WIDTH*4  head entry of every column FIFO; column 0 in LSBs.
- overflow  output  1  sticky: a push was dropped because a column FIFO was full.
- row_count  output  16  rows delivered since reset/clear; wraps at 2^16.

Behaviour:
- Column FIFO state: one circular buffer per column with wr_ptr, rd_ptr (log2(DEPTH) bits) and count (log2(DEPTH)+1 bits).
- Reset: all counts and pointers 0, out_valid 0, overflow 0, row_count 0. Storage is not reset. Reset mid-stream discards all buffered data immediately.
- Push: on a clk edge with col_valid[j]=1, if count_j < DEPTH or a pop occurs in the same cycle, write col_psum[j] at wr_ptr_j and increment wr_ptr_j (wraps DEPTH-1 -> 0).
- Dropped push: if col_valid[j]=1, count_j == DEPTH and no pop occurs, the data is dropped and overflow is set. overflow stays set until reset or clear.
- out_valid: combinational AND of (count_j != 0) over all j, decoded from registered counts only. It never depends on col_valid in the same cycle.
- Latency: minimum push-to-visibility latency is one cycle. A row becomes valid the cycle after its last (most-skewed) column is pushed.
- out_row: heads of all FIFOs when out_valid=1; all zeros when out_valid=0. It holds stable while out_valid=1 and out_ready=0.
- Pop: when out_valid && out_ready at an edge, every column increments rd_ptr and decrements count, and row_count increments (mod 2^16). out_ready with out_valid=0 has no effect.
- Simultaneous push and pop on a column: count unchanged. This applies when full as well, so the push is accepted. FIFO order is preserved.
- Columns are independent: a column may be ahead of others by up to DEPTH entries. Rows assemble strictly in per-column arrival order.
- clear: on an edge with clear=1, all counts and pointers are zeroed, overflow and row_count are cleared, and same-cycle pushes and pops are discarded. clear has priority over everything except reset.
- There are no combinational paths from col_valid/col_psum to outputs. The only input-to-output combinational path is none; out_ready affects state only.

Decomposition:
- Shared package: PSUM_WIDTH = WORD_WIDTH*4; PTR_WIDTH = $clog2(DEPTH); CNT_WIDTH = PTR_WIDTH+1; ROW_COUNT_WIDTH = 16.
- Sub-module psum_column_fifo, instantiated COLS times.
  - Ports: clk, reset, clear, push, push_data, pop, head, empty, full, drop.
- Top level: out_valid AND-reduction, pop broadcast, overflow OR-reduction of drop, row_count counter.

Test Plan:
- Reset mid-stream: push 3 rows, assert reset for 1 cycle -> next cycle out_valid=0, overflow=0, row_count=0, out_row=0. A following single row emerges alone.
- Skewed row, COLS=4, out_ready=1: column j pushes 0x100+j at cycle j (j=0..3) -> out_valid high exactly at cycle 4 with out_row = {0x103,0x102,0x101,0x100}. Popped that cycle; row_count=1.
- Backpressure and overflow: out_ready=0, push 8 aligned rows (row r, column j = 16*r+j) -> all columns full, out_valid=1, row 0 held stable. A 9th push to column 0 -> overflow=1, data dropped. Then out_ready=1 -> rows 0..7 in order, row_count=8, out_valid=0 after.
- Full push+pop: all columns full, out_ready=1 and all col_valid=1 with value 0xAA -> count stays 8, overflow stays 0. 0xAA delivered after the 8 older rows.
- clear priority: FIFOs hold 2 rows and overflow=1; assert clear together with col_valid=all and out_ready=1 -> next cycle out_valid=0, overflow=0, row_count=0, the concurrent push absent.
- Pointer wrap: stream 20 skewed rows with out_ready toggling every other cycle -> all 20 rows delivered in order, intact, row_count=20, overflow=0.
